// File: rtl/bank_write_scheduler.sv
// Schedules per-port vector-register writes onto banked VRF write ports with round-robin
// fairness, starvation escalation, same-row collision deferral and a registered write stage.
module bank_write_scheduler #(
  parameter int unsigned PORT_NUM        = 4,
  parameter int unsigned NUM_BANK        = 4,
  parameter int unsigned WRITE_BANK_PORT = 1,
  parameter int unsigned ADDR_WIDTH      = 6,
  parameter int unsigned BANK_WIDTH      = 2,
  parameter int unsigned ROW_WIDTH       = 4,
  parameter int unsigned ROW_SIZE        = 16,
  parameter int unsigned DATA_WIDTH      = 128,
  parameter int unsigned STARVE_LIMIT    = 7
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic [PORT_NUM-1:0]                             wr_valid,
  input  logic [PORT_NUM*ADDR_WIDTH-1:0]                  wr_addr,
  input  logic [PORT_NUM*DATA_WIDTH-1:0]                  wr_data,
  output logic [PORT_NUM-1:0]                             wr_ready,
  output logic [NUM_BANK*WRITE_BANK_PORT-1:0]             bank_we,
  output logic [NUM_BANK*WRITE_BANK_PORT*ROW_WIDTH-1:0]   bank_waddr,
  output logic [NUM_BANK*WRITE_BANK_PORT*DATA_WIDTH-1:0]  bank_wdata,
  output logic [NUM_BANK*WRITE_BANK_PORT*PORT_NUM-1:0]    bank_wsrc,
  output logic [PORT_NUM-1:0]                             err_oor
);

  localparam int unsigned NumSlot = NUM_BANK * WRITE_BANK_PORT;
  localparam int unsigned PtrW    = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
  localparam int unsigned SlotW   = (NumSlot > 1) ? $clog2(NumSlot) : 1;
  localparam int unsigned CntW    = $clog2(STARVE_LIMIT + 1);

  logic [PORT_NUM-1:0][ADDR_WIDTH-1:0] addr;
  logic [PORT_NUM-1:0][DATA_WIDTH-1:0] wdat;
  logic [PORT_NUM-1:0][ROW_WIDTH-1:0]  row;
  logic [PORT_NUM-1:0][BANK_WIDTH-1:0] bank;
  logic [PORT_NUM-1:0]                 oor, inrange, esc, grant;

  logic [NUM_BANK-1:0][PtrW-1:0]       rr_d, rr_q;
  logic [PORT_NUM-1:0][CntW-1:0]       starve_d, starve_q;

  logic [NumSlot-1:0]                  we_d, we_q;
  logic [NumSlot-1:0][ROW_WIDTH-1:0]   waddr_d, waddr_q;
  logic [NumSlot-1:0][DATA_WIDTH-1:0]  wdata_d, wdata_q;
  logic [NumSlot-1:0][PORT_NUM-1:0]    wsrc_d, wsrc_q;
  logic [PORT_NUM-1:0]                 err_q;

  assign addr = wr_addr;
  assign wdat = wr_data;

  always_comb begin
    row     = '0;
    bank    = '0;
    oor     = '0;
    inrange = '0;
    esc     = '0;
    for (int unsigned q = 0; q < PORT_NUM; q++) begin
      row[q]     = addr[q][BANK_WIDTH +: ROW_WIDTH];
      bank[q]    = addr[q][BANK_WIDTH-1:0];
      oor[q]     = wr_valid[q] && (32'(row[q]) >= ROW_SIZE);
      inrange[q] = wr_valid[q] && !oor[q];
      esc[q]     = (starve_q[q] == CntW'(STARVE_LIMIT));
    end
  end

  // Two passes per bank: escalated ports first, then the rest, both rotating from rr_q.
  always_comb begin
    logic [PtrW-1:0]  p;
    logic [SlotW-1:0] idx;
    int unsigned      n;
    logic             hit;
    grant   = '0;
    we_d    = '0;
    waddr_d = '0;
    wdata_d = '0;
    wsrc_d  = '0;
    rr_d    = rr_q;
    p       = '0;
    idx     = '0;
    n       = 0;
    hit     = 1'b0;
    for (int unsigned b = 0; b < NUM_BANK; b++) begin
      n = 0;
      for (int unsigned c = 0; c < 2; c++) begin
        for (int unsigned i = 0; i < PORT_NUM; i++) begin
          p   = PtrW'((32'(rr_q[b]) + i) % PORT_NUM);
          hit = 1'b0;
          for (int unsigned s = 0; s < WRITE_BANK_PORT; s++) begin
            if (we_d[b*WRITE_BANK_PORT+s] && (waddr_d[b*WRITE_BANK_PORT+s] == row[p])) begin
              hit = 1'b1;
            end
          end
          if (inrange[p] && (bank[p] == BANK_WIDTH'(b)) && (esc[p] == (c == 0)) &&
              (n < WRITE_BANK_PORT) && !hit) begin
            idx            = SlotW'(b * WRITE_BANK_PORT + n);
            grant[p]       = 1'b1;
            we_d[idx]      = 1'b1;
            waddr_d[idx]   = row[p];
            wdata_d[idx]   = wdat[p];
            wsrc_d[idx][p] = 1'b1;
            rr_d[b]        = PtrW'((32'(p) + 1) % PORT_NUM);
            n              = n + 1;
          end
        end
      end
    end
  end

  assign wr_ready = {PORT_NUM{rst_n}} & (oor | grant);

  always_comb begin
    starve_d = starve_q;
    for (int unsigned q = 0; q < PORT_NUM; q++) begin
      if (!wr_valid[q] || wr_ready[q]) begin
        starve_d[q] = '0;
      end else if (inrange[q] && (starve_q[q] != CntW'(STARVE_LIMIT))) begin
        starve_d[q] = starve_q[q] + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_q     <= '0;
      starve_q <= '0;
      we_q     <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wsrc_q   <= '0;
      err_q    <= '0;
    end else begin
      rr_q     <= rr_d;
      starve_q <= starve_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      wsrc_q   <= wsrc_d;
      err_q    <= oor;
    end
  end

  assign bank_we    = we_q;
  assign bank_waddr = waddr_q;
  assign bank_wdata = wdata_q;
  assign bank_wsrc  = wsrc_q;
  assign err_oor    = err_q;

endmodule
